mem_access_unit: RTL and testbench

//  Load/store front end between the core's memory stage and the word-organised ram_memory.

---
 rtl/mem_access_unit_if.sv | 34 +++
 rtl/mem_access_unit.sv | 194 +++++++++++++++++++
 tb/tb_mem_access_unit.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_unit_if.sv
// Request/response and word-RAM signal bundle of mem_access_unit.
// slave = the access unit itself; master = the core and RAM side that drive it.
interface mem_access_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_error;
    logic        ram_write_en;
    logic [31:0] ram_addr_write;
    logic [31:0] ram_data_write;
    logic [31:0] ram_addr_read;
    logic [31:0] ram_data_read;
    logic        ram_ready;

    modport slave (
        input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
        input  ram_data_read, ram_ready,
        output req_ready, resp_valid, resp_rdata, resp_error,
        output ram_write_en, ram_addr_write, ram_data_write, ram_addr_read
    );

    modport master (
        output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
        output ram_data_read, ram_ready,
        input  req_ready, resp_valid, resp_rdata, resp_error,
        input  ram_write_en, ram_addr_write, ram_data_write, ram_addr_read
    );
endinterface

// File: rtl/mem_access_unit.sv
// Byte/half/word load-store front end over a word RAM; latency from accept: error 1, load 2, word store 2, sub-word store 3 (RMW).
// One request in flight, req_ready only in IDLE with ram_ready; MAU_PERF_COUNT_EN adds load/store/error counters (else tied 0).
module mem_access_unit #(
    parameter int unsigned BUS_WIDTH = 32,
    parameter logic [31:0] RAM_BASE  = 32'h0000_0000,
    parameter int unsigned MEM_SIZE  = 256
) (
    input  logic                 clk,
    input  logic                 nreset,
    mem_access_unit_if.slave     bus,
    output logic [BUS_WIDTH-1:0] cnt_load,
    output logic [BUS_WIDTH-1:0] cnt_store,
    output logic [BUS_WIDTH-1:0] cnt_error
);
    typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_WRITE, ST_RESP} state_e;

    localparam logic [1:0]  SZ_BYTE = 2'd0;
    localparam logic [1:0]  SZ_HALF = 2'd1;
    localparam logic [1:0]  SZ_WORD = 2'd2;
    localparam logic [32:0] RAM_END = {1'b0, RAM_BASE} + 33'(4 * MEM_SIZE);

    state_e      state_q, state_d;
    logic        write_q, write_d;
    logic [1:0]  size_q, size_d;
    logic        sext_q, sext_d;
    logic [1:0]  lane_q, lane_d;
    logic [31:0] waddr_q, waddr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        error_q, error_d;

    logic        req_rdy;
    logic        accept;
    logic        align_err;
    logic        range_err;
    logic        req_err;
    logic [31:0] word_addr;
    logic [4:0]  shamt;
    logic [31:0] rd_shifted;
    logic [31:0] load_val;
    logic [31:0] lane_mask;
    logic [31:0] merged;

    assign req_rdy = (state_q == ST_IDLE) && bus.ram_ready;
    assign accept  = req_rdy && bus.req_valid;

    // Request checks; the range compare is done in 33 bits so addresses near 2^32 cannot wrap into range.
    always_comb begin
        align_err = 1'b0;
        case (bus.req_size)
            SZ_BYTE: align_err = 1'b0;
            SZ_HALF: align_err = bus.req_addr[0];
            SZ_WORD: align_err = |bus.req_addr[1:0];
            default: align_err = 1'b1;
        endcase
        range_err = ({1'b0, bus.req_addr} < {1'b0, RAM_BASE}) ||
                    ({1'b0, bus.req_addr} >= RAM_END);
        req_err   = align_err || range_err;
        word_addr = RAM_BASE + ((bus.req_addr - RAM_BASE) >> 2);
    end

    // Lane alignment for loads and the read-modify-write merge for sub-word stores.
    always_comb begin
        shamt      = {lane_q, 3'b000};
        rd_shifted = bus.ram_data_read >> shamt;
        case (size_q)
            SZ_BYTE: load_val = {{24{sext_q & rd_shifted[7]}}, rd_shifted[7:0]};
            SZ_HALF: load_val = {{16{sext_q & rd_shifted[15]}}, rd_shifted[15:0]};
            default: load_val = bus.ram_data_read;
        endcase
        if (size_q == SZ_HALF) lane_mask = 32'h0000_FFFF << shamt;
        else                   lane_mask = 32'h0000_00FF << shamt;
        merged = (bus.ram_data_read & ~lane_mask) | ((wdata_q << shamt) & lane_mask);
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (req_err)                                    state_d = ST_RESP;
                    else if (bus.req_write && bus.req_size == SZ_WORD) state_d = ST_WRITE;
                    else                                            state_d = ST_READ;
                end
            end
            ST_READ:  state_d = write_q ? ST_WRITE : ST_RESP;
            ST_WRITE: state_d = ST_RESP;
            ST_RESP:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        write_d = write_q;
        size_d  = size_q;
        sext_d  = sext_q;
        lane_d  = lane_q;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        error_d = error_q;
        if (accept) begin
            write_d = bus.req_write;
            size_d  = bus.req_size;
            sext_d  = bus.req_signed;
            lane_d  = bus.req_addr[1:0];
            waddr_d = word_addr;
            wdata_d = bus.req_wdata;
            rdata_d = '0;
            error_d = req_err;
        end else if (state_q == ST_READ) begin
            if (write_q) wdata_d = merged;
            else         rdata_d = load_val;
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            write_q <= 1'b0;
            size_q  <= 2'd0;
            sext_q  <= 1'b0;
            lane_q  <= 2'd0;
            waddr_q <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            error_q <= 1'b0;
        end else begin
            write_q <= write_d;
            size_q  <= size_d;
            sext_q  <= sext_d;
            lane_q  <= lane_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            error_q <= error_d;
        end
    end

    always_comb begin
        bus.req_ready      = req_rdy;
        bus.ram_addr_read  = (state_q != ST_IDLE) ? waddr_q : '0;
        bus.ram_addr_write = (state_q != ST_IDLE) ? waddr_q : '0;
        bus.ram_write_en   = (state_q == ST_WRITE);
        bus.ram_data_write = (state_q == ST_WRITE) ? wdata_q : '0;
        bus.resp_valid     = (state_q == ST_RESP);
        bus.resp_rdata     = (state_q == ST_RESP) ? rdata_q : '0;
        bus.resp_error     = (state_q == ST_RESP) && error_q;
    end

`ifdef MAU_PERF_COUNT_EN
    logic [BUS_WIDTH-1:0] cnt_load_q, cnt_load_d;
    logic [BUS_WIDTH-1:0] cnt_store_q, cnt_store_d;
    logic [BUS_WIDTH-1:0] cnt_error_q, cnt_error_d;

    always_comb begin
        cnt_load_d  = cnt_load_q;
        cnt_store_d = cnt_store_q;
        cnt_error_d = cnt_error_q;
        if (state_q == ST_RESP) begin
            if (error_q)      cnt_error_d = cnt_error_q + BUS_WIDTH'(1);
            else if (write_q) cnt_store_d = cnt_store_q + BUS_WIDTH'(1);
            else              cnt_load_d  = cnt_load_q + BUS_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            cnt_load_q  <= '0;
            cnt_store_q <= '0;
            cnt_error_q <= '0;
        end else begin
            cnt_load_q  <= cnt_load_d;
            cnt_store_q <= cnt_store_d;
            cnt_error_q <= cnt_error_d;
        end
    end

    assign cnt_load  = cnt_load_q;
    assign cnt_store = cnt_store_q;
    assign cnt_error = cnt_error_q;
`else
    assign cnt_load  = '0;
    assign cnt_store = '0;
    assign cnt_error = '0;
`endif
endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized bench for mem_access_unit against a byte-array memory model, plus directed reset/RMW/error cases.
module tb_mem_access_unit;
    localparam logic [31:0] RAM_BASE = 32'h0000_1000;
    localparam int          MEM_SIZE = 64;

    logic clk;
    logic nreset;
    logic [31:0] cnt_load, cnt_store, cnt_error;

    mem_access_unit_if bus ();

    mem_access_unit #(.BUS_WIDTH(32), .RAM_BASE(RAM_BASE), .MEM_SIZE(MEM_SIZE)) dut (
        .clk       (clk),
        .nreset    (nreset),
        .bus       (bus),
        .cnt_load  (cnt_load),
        .cnt_store (cnt_store),
        .cnt_error (cnt_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Word RAM with combinational read, preloaded through a side port.
    logic [31:0] ram [MEM_SIZE];
    logic        ld_en;
    int          ld_idx;
    logic [31:0] ld_dat;
    logic [31:0] rd_idx, wr_idx;

    always_comb begin
        rd_idx = bus.ram_addr_read - RAM_BASE;
        bus.ram_data_read = (rd_idx < MEM_SIZE) ? ram[rd_idx[5:0]] : 32'h0;
    end

    always @(posedge clk) begin
        wr_idx = bus.ram_addr_write - RAM_BASE;
        if (ld_en) ram[ld_idx] <= ld_dat;
        else if (bus.ram_write_en && wr_idx < MEM_SIZE) ram[wr_idx[5:0]] <= bus.ram_data_write;
    end

    // Reference model: byte-addressed memory image and response counts.
    logic [7:0] ref_mem [4*MEM_SIZE];
    int m_load, m_store, m_err;
    int n_chk, n_err;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_word(input int w);
        return {ref_mem[4*w+3], ref_mem[4*w+2], ref_mem[4*w+1], ref_mem[4*w]};
    endfunction

    function automatic logic model_err(input logic [1:0] sz, input logic [31:0] a);
        longint unsigned la, lo, hi;
        la = 64'(a);
        lo = 64'(RAM_BASE);
        hi = lo + 64'(4 * MEM_SIZE);
        if (sz == 2'd3) return 1'b1;
        if (sz == 2'd1 && a[0]) return 1'b1;
        if (sz == 2'd2 && a[1:0] != 2'b00) return 1'b1;
        if (la < lo || la >= hi) return 1'b1;
        return 1'b0;
    endfunction

    task automatic check_counters(input string tag);
`ifdef MAU_PERF_COUNT_EN
        chk({tag, "_cnt_load"},  cnt_load,  32'(m_load));
        chk({tag, "_cnt_store"}, cnt_store, 32'(m_store));
        chk({tag, "_cnt_error"}, cnt_error, 32'(m_err));
`else
        chk({tag, "_cnt_load"},  cnt_load,  32'h0);
        chk({tag, "_cnt_store"}, cnt_store, 32'h0);
        chk({tag, "_cnt_error"}, cnt_error, 32'h0);
`endif
    endtask

    task automatic do_req(input logic wr, input logic [1:0] sz, input logic sg,
                          input logic [31:0] a, input logic [31:0] wd, output logic [31:0] got);
        int guard, lat, exp_lat, wen_n, rdy_busy, nb;
        logic [31:0] waddr, exp_val, off;
        logic exp_err;
        guard = 0;
        while (!bus.req_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        chk("req_ready_idle", 32'(bus.req_ready), 32'd1);
        bus.req_valid  = 1'b1;
        bus.req_write  = wr;
        bus.req_size   = sz;
        bus.req_signed = sg;
        bus.req_addr   = a;
        bus.req_wdata  = wd;
        lat = 0; wen_n = 0; rdy_busy = 0; waddr = 32'h0;
        do begin
            @(negedge clk);
            lat++;
            bus.req_valid = 1'b0;
            bus.req_addr  = $urandom;
            bus.req_wdata = $urandom;
            bus.req_size  = 2'($urandom_range(0, 3));
            if (bus.req_ready) rdy_busy++;
            if (bus.ram_write_en) begin
                wen_n++;
                waddr = bus.ram_addr_write;
            end
        end while (!bus.resp_valid && lat < 8);

        exp_err = model_err(sz, a);
        exp_lat = exp_err ? 1 : (!wr ? 2 : (sz == 2'd2 ? 2 : 3));
        exp_val = 32'h0;
        chk("resp_valid", 32'(bus.resp_valid), 32'd1);
        chk("latency", 32'(lat), 32'(exp_lat));
        chk("resp_error", 32'(bus.resp_error), 32'(exp_err));
        chk("ready_while_busy", 32'(rdy_busy), 32'd0);
        chk("write_en_cycles", 32'(wen_n), (!exp_err && wr) ? 32'd1 : 32'd0);
        off = a - RAM_BASE;
        nb  = 1 << sz;
        if (exp_err) begin
            m_err++;
        end else if (wr) begin
            m_store++;
            chk("ram_addr_write", waddr, RAM_BASE + (off >> 2));
            for (int i = 0; i < nb; i++) ref_mem[int'(off) + i] = 8'(wd >> (8 * i));
        end else begin
            m_load++;
            for (int i = 0; i < nb; i++) exp_val |= 32'(ref_mem[int'(off) + i]) << (8 * i);
            if (sg && nb < 4 && exp_val[8*nb-1]) exp_val |= ~((32'd1 << (8 * nb)) - 32'd1);
        end
        chk("resp_rdata", bus.resp_rdata, exp_val);
        got = bus.resp_rdata;
        @(negedge clk);
        chk("resp_one_cycle", 32'(bus.resp_valid), 32'd0);
        if (!exp_err && wr) chk("ram_word_after_store", ram[off[7:2]], ref_word(int'(off >> 2)));
    endtask

    logic [31:0] got, a, old_word, errs_addr [5];
    logic [1:0]  sz, errs_size [5];
    int          r, guard, mism;

    initial begin
        n_chk = 0; n_err = 0; m_load = 0; m_store = 0; m_err = 0;
        nreset = 1'b0;
        bus.ram_ready  = 1'b0;
        bus.req_valid  = 1'b0;
        bus.req_write  = 1'b0;
        bus.req_size   = 2'd0;
        bus.req_signed = 1'b0;
        bus.req_addr   = 32'h0;
        bus.req_wdata  = 32'h0;
        ld_en = 1'b0; ld_idx = 0; ld_dat = 32'h0;

        for (int i = 0; i < MEM_SIZE; i++) begin
            ld_dat = $urandom;
            ld_idx = i;
            ld_en  = 1'b1;
            for (int b = 0; b < 4; b++) ref_mem[4*i+b] = 8'(ld_dat >> (8 * b));
            @(negedge clk);
        end
        ld_en = 1'b0;

        chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
        chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("rst_resp_rdata", bus.resp_rdata, 32'h0);
        chk("rst_resp_error", 32'(bus.resp_error), 32'd0);
        chk("rst_write_en", 32'(bus.ram_write_en), 32'd0);
        chk("rst_addr_write", bus.ram_addr_write, 32'h0);
        chk("rst_data_write", bus.ram_data_write, 32'h0);
        chk("rst_addr_read", bus.ram_addr_read, 32'h0);
        check_counters("rst");

        nreset = 1'b1;
        @(negedge clk);
        chk("no_ready_without_ram", 32'(bus.req_ready), 32'd0);
        bus.ram_ready = 1'b1;
        #1;
        chk("ready_after_reset", 32'(bus.req_ready), 32'd1);

        do_req(1'b1, 2'd2, 1'b0, RAM_BASE + 32'd8, 32'hDEADBEEF, got);
        do_req(1'b0, 2'd2, 1'b1, RAM_BASE + 32'd8, 32'h0, got);
        chk("word_load_value", got, 32'hDEADBEEF);

        do_req(1'b1, 2'd2, 1'b0, RAM_BASE + 32'd4, 32'h11223344, got);
        do_req(1'b1, 2'd0, 1'b0, RAM_BASE + 32'd6, 32'h123456AA, got);
        chk("byte_rmw_word", ram[1], 32'h11AA3344);
        do_req(1'b0, 2'd0, 1'b1, RAM_BASE + 32'd6, 32'h0, got);
        chk("byte_load_signed", got, 32'hFFFFFFAA);
        do_req(1'b0, 2'd0, 1'b0, RAM_BASE + 32'd6, 32'h0, got);
        chk("byte_load_unsigned", got, 32'h000000AA);
        do_req(1'b1, 2'd1, 1'b0, RAM_BASE + 32'd6, 32'h0000_8001, got);
        do_req(1'b0, 2'd1, 1'b1, RAM_BASE + 32'd6, 32'h0, got);
        chk("half_load_signed", got, 32'hFFFF8001);

        errs_addr[0] = RAM_BASE + 32'd1;                 errs_size[0] = 2'd1;
        errs_addr[1] = RAM_BASE + 32'd2;                 errs_size[1] = 2'd2;
        errs_addr[2] = RAM_BASE;                         errs_size[2] = 2'd3;
        errs_addr[3] = RAM_BASE + 32'(4 * MEM_SIZE);     errs_size[3] = 2'd0;
        errs_addr[4] = 32'hFFFF_FFFC;                    errs_size[4] = 2'd2;
        for (int i = 0; i < 5; i++) begin
            do_req(1'b1, errs_size[i], 1'b0, errs_addr[i], 32'h5555_5555, got);
            do_req(1'b0, errs_size[i], 1'b1, errs_addr[i], 32'h0, got);
        end
        do_req(1'b0, 2'd2, 1'b0, RAM_BASE + 32'(4 * MEM_SIZE) - 32'd4, 32'h0, got);
        do_req(1'b0, 2'd0, 1'b0, RAM_BASE - 32'd1, 32'h0, got);

        for (int t = 0; t < 250; t++) begin
            r = $urandom_range(0, 9);
            if (r == 0)      a = $urandom;
            else if (r == 1) a = RAM_BASE + 32'(4 * MEM_SIZE) + 32'($urandom_range(0, 7));
            else if (r == 2) a = RAM_BASE - 32'($urandom_range(1, 4));
            else             a = RAM_BASE + 32'($urandom_range(0, 4 * MEM_SIZE - 1));
            sz = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            if ($urandom_range(0, 4) != 0) begin
                if (sz == 2'd1) a[0] = 1'b0;
                if (sz == 2'd2) a[1:0] = 2'b00;
            end
            do_req(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom, got);
        end
        check_counters("random");

        // Reset while the merged write of a byte store is on the RAM port.
        old_word = ram[3];
        guard = 0;
        while (!bus.req_ready && guard < 20) begin @(negedge clk); guard++; end
        bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_size = 2'd0;
        bus.req_signed = 1'b0; bus.req_addr = RAM_BASE + 32'd13; bus.req_wdata = 32'h0000_005A;
        guard = 0;
        do begin
            @(negedge clk);
            bus.req_valid = 1'b0;
            guard++;
        end while (!bus.ram_write_en && guard < 8);
        chk("rmw_reached_write", 32'(bus.ram_write_en), 32'd1);
        nreset = 1'b0;
        #1;
        chk("rst_mid_write_en", 32'(bus.ram_write_en), 32'd0);
        chk("rst_mid_addr_write", bus.ram_addr_write, 32'h0);
        @(negedge clk);
        chk("rst_mid_no_resp", 32'(bus.resp_valid), 32'd0);
        chk("rst_mid_ram_kept", ram[3], old_word);
        chk("rst_mid_ram_model", ram[3], ref_word(3));
        nreset = 1'b1;
        m_load = 0; m_store = 0; m_err = 0;
        @(negedge clk);
        chk("rst_mid_no_resp_after", 32'(bus.resp_valid), 32'd0);
        check_counters("after_reset");

        do_req(1'b0, 2'd2, 1'b0, RAM_BASE + 32'd16, 32'h0, got);
        do_req(1'b0, 2'd0, 1'b1, RAM_BASE + 32'd17, 32'h0, got);
        do_req(1'b0, 2'd1, 1'b0, RAM_BASE + 32'd18, 32'h0, got);
        do_req(1'b1, 2'd2, 1'b0, RAM_BASE + 32'd20, 32'hCAFE_F00D, got);
        do_req(1'b1, 2'd1, 1'b0, RAM_BASE + 32'd22, 32'h0000_BEEF, got);
        do_req(1'b0, 2'd2, 1'b0, RAM_BASE + 32'd21, 32'h0, got);
        check_counters("perf");

        mism = 0;
        for (int w = 0; w < MEM_SIZE; w++) if (ram[w] !== ref_word(w)) mism++;
        chk("ram_image_mismatches", 32'(mism), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
